// File: rtl/inta_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : inta_sequencer_if
// Purpose  : CPU/resolver-facing signals of the 8259A INTA sequencer:
//            request in, INT out, INTA strobe in, vector byte out.
// Revision : 1.0 - initial release
// ============================================================================
interface inta_sequencer_if;
    logic       int_req;     // resolved pending request (level)
    logic [2:0] int_num;     // resolved IR number
    logic       inta_n;      // CPU acknowledge strobe, async, active-low
    logic       int_out;     // INT pin to CPU
    logic [1:0] inta_count;  // handshake progress for resolver/control
    logic [7:0] data_out;    // vector byte
    logic       data_oe;     // data bus drive enable

    // Sequencer side
    modport slave (
        input  int_req, int_num, inta_n,
        output int_out, inta_count, data_out, data_oe
    );

    // Resolver/CPU side
    modport master (
        output int_req, int_num, inta_n,
        input  int_out, inta_count, data_out, data_oe
    );
endinterface
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inta_sequencer
// Purpose  : Drives INT to the CPU, runs the two-pulse 8086 INTA handshake,
//            owns the in-service register, places the vector byte on the
//            bus during the 2nd INTA and applies EOI / automatic EOI.
// Revision : 1.0 - initial release
// ============================================================================
module inta_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       internal_clk,
    input  logic       reset,
    inta_sequencer_if.slave bus,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       eoi_cmd,
    input  logic       seoi_cmd,
    input  logic [2:0] seoi_level,
    output logic [7:0] isr,
    output logic       eoi_pulse
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ACK1  = 3'd2,
        S_WAIT2 = 3'd3,
        S_ACK2  = 3'd4
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  inta_sync;
    logic                    inta_last;
    logic                    fall;
    logic                    rise;
    logic [2:0]              cur_num;
    logic                    spurious;
    logic [CNT_W-1:0]        ack_cnt;
    logic [7:0]              set_mask;
    logic [7:0]              clr_mask;

    // Synchronize the asynchronous INTA strobe and turn its edges into
    // registered one-cycle fall/rise strobes. Flops reset to the idle (high)
    // level so that reset release never fakes an edge.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            inta_sync <= '1;
            inta_last <= 1'b1;
            fall      <= 1'b0;
            rise      <= 1'b0;
        end else begin
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], bus.inta_n};
            inta_last <= inta_sync[SYNC_STAGES-1];
            fall      <= inta_last & ~inta_sync[SYNC_STAGES-1];
            rise      <= ~inta_last & inta_sync[SYNC_STAGES-1];
        end
    end

    // ISR set/clear requests for this cycle. Specific EOI overrides the
    // non-specific one; AEOI clear is independent and merged in. Clears are
    // masked with the current ISR so a clear of an empty bit is a no-op.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (state == S_REQ && fall && bus.int_req) begin
            set_mask = 8'b1 << bus.int_num;
        end
        if (seoi_cmd) begin
            clr_mask = isr & (8'b1 << seoi_level);
        end else if (eoi_cmd) begin
            // isr & -isr isolates the lowest-index (highest priority) set bit
            clr_mask = isr & (~isr + 8'd1);
        end
        if (state == S_ACK2 && rise && aeoi && !spurious) begin
            clr_mask = clr_mask | (isr & (8'b1 << cur_num));
        end
    end

    // Handshake state machine with registered outputs and ISR ownership.
    // A set of the same bit in the same cycle beats its clear.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            bus.int_out    <= 1'b0;
            bus.inta_count <= 2'd0;
            bus.data_out   <= 8'h00;
            bus.data_oe    <= 1'b0;
            isr            <= 8'h00;
            eoi_pulse      <= 1'b0;
            cur_num        <= 3'd0;
            spurious       <= 1'b0;
            ack_cnt        <= '0;
        end else begin
            isr       <= (isr & ~clr_mask) | set_mask;
            eoi_pulse <= |(clr_mask & ~set_mask);

            case (state)
                S_IDLE: begin
                    if (bus.int_req) begin
                        state       <= S_REQ;
                        bus.int_out <= 1'b1;
                    end
                end

                // INT stays asserted even if the request goes away; the CPU
                // will still acknowledge and gets the spurious IR7 vector.
                S_REQ: begin
                    if (fall) begin
                        state          <= S_ACK1;
                        bus.int_out    <= 1'b0;
                        bus.inta_count <= 2'd1;
                        if (bus.int_req) begin
                            cur_num  <= bus.int_num;
                            spurious <= 1'b0;
                        end else begin
                            cur_num  <= 3'd7;
                            spurious <= 1'b1;
                        end
                    end
                end

                S_ACK1: begin
                    if (rise) begin
                        state   <= S_WAIT2;
                        ack_cnt <= '0;
                    end
                end

                // Abandon the cycle if the CPU never sends the 2nd INTA;
                // the ISR bit stays set for software to clean up.
                S_WAIT2: begin
                    if (fall) begin
                        state          <= S_ACK2;
                        bus.data_out   <= {vector_base, cur_num};
                        bus.data_oe    <= 1'b1;
                        bus.inta_count <= 2'd2;
                    end else if (ack_cnt == TIMEOUT_VAL) begin
                        state          <= S_IDLE;
                        bus.inta_count <= 2'd0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                S_ACK2: begin
                    if (rise) begin
                        state          <= S_IDLE;
                        bus.data_oe    <= 1'b0;
                        bus.inta_count <= 2'd0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
